dcache_bypass_axi_if: RTL and testbench

- Downstream stage of the nonblocking L1 dcache bypass path.
- Converts single-word uncached requests from the miss handler (bypass arbiter output) into single-beat AXI4 transactions on the bypass master port.
- Returns read data or a write acknowledge to the miss handler.
- Allows one transaction outstanding at a time; in-order by construction.

---
 rtl/dcache_bypass_axi_if_pkg.sv | 38 +++
 rtl/dcache_bypass_axi_if_if.sv | 67 ++++++
 rtl/dcache_bypass_axi_if.sv | 146 ++++++++++++++
 tb/tb_dcache_bypass_axi_if.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_bypass_axi_if_pkg.sv
// Shared types for the dcache bypass AXI stage: latched request, response,
// FSM state encoding and the AXI constants it drives.
package dcache_bypass_axi_if_pkg;

  localparam int BYPASS_ADDR_WIDTH = 64;
  localparam int BYPASS_DATA_WIDTH = 64;
  localparam int BYPASS_BE_WIDTH   = BYPASS_DATA_WIDTH / 8;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA
  } axi_bypass_state_e;

  typedef struct packed {
    logic                         we;
    logic [BYPASS_ADDR_WIDTH-1:0] addr;
    logic [BYPASS_DATA_WIDTH-1:0] wdata;
    logic [BYPASS_BE_WIDTH-1:0]   be;
    logic [1:0]                   size;
  } bypass_req_t;

  typedef struct packed {
    logic [BYPASS_DATA_WIDTH-1:0] rdata;
    logic                         err;
  } bypass_rsp_t;

  // Anything other than OKAY (SLVERR, DECERR, EXOKAY) is reported as an error.
  function automatic logic axi_resp_is_err(input logic [1:0] resp);
    return resp != AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/dcache_bypass_axi_if_if.sv
// Flat AXI4 bypass master bus (AW/W/B/AR/R); master modport is the cache side,
// slave modport is the interconnect / memory side.
interface dcache_bypass_axi_if_if #(
  parameter int AXI_ID_WIDTH = 4,
  parameter int ADDR_WIDTH   = 64,
  parameter int DATA_WIDTH   = 64
);

  logic                    aw_valid_o;
  logic                    aw_ready_i;
  logic [ADDR_WIDTH-1:0]   aw_addr_o;
  logic [2:0]              aw_size_o;
  logic [7:0]              aw_len_o;
  logic [1:0]              aw_burst_o;
  logic [AXI_ID_WIDTH-1:0] aw_id_o;

  logic                    w_valid_o;
  logic                    w_ready_i;
  logic [DATA_WIDTH-1:0]   w_data_o;
  logic [DATA_WIDTH/8-1:0] w_strb_o;
  logic                    w_last_o;

  logic                    b_valid_i;
  logic                    b_ready_o;
  logic [1:0]              b_resp_i;

  logic                    ar_valid_o;
  logic                    ar_ready_i;
  logic [ADDR_WIDTH-1:0]   ar_addr_o;
  logic [2:0]              ar_size_o;
  logic [7:0]              ar_len_o;
  logic [1:0]              ar_burst_o;
  logic [AXI_ID_WIDTH-1:0] ar_id_o;

  logic                    r_valid_i;
  logic                    r_ready_o;
  logic [DATA_WIDTH-1:0]   r_data_i;
  logic [1:0]              r_resp_i;
  logic                    r_last_i;

  modport master (
    output aw_valid_o, aw_addr_o, aw_size_o, aw_len_o, aw_burst_o, aw_id_o,
    input  aw_ready_i,
    output w_valid_o, w_data_o, w_strb_o, w_last_o,
    input  w_ready_i,
    input  b_valid_i, b_resp_i,
    output b_ready_o,
    output ar_valid_o, ar_addr_o, ar_size_o, ar_len_o, ar_burst_o, ar_id_o,
    input  ar_ready_i,
    input  r_valid_i, r_data_i, r_resp_i, r_last_i,
    output r_ready_o
  );

  modport slave (
    input  aw_valid_o, aw_addr_o, aw_size_o, aw_len_o, aw_burst_o, aw_id_o,
    output aw_ready_i,
    input  w_valid_o, w_data_o, w_strb_o, w_last_o,
    output w_ready_i,
    output b_valid_i, b_resp_i,
    input  b_ready_o,
    input  ar_valid_o, ar_addr_o, ar_size_o, ar_len_o, ar_burst_o, ar_id_o,
    output ar_ready_i,
    output r_valid_i, r_data_i, r_resp_i, r_last_i,
    input  r_ready_o
  );

endinterface

// File: rtl/dcache_bypass_axi_if.sv
// Turns single-word uncached bypass requests into single-beat AXI4 transactions,
// one outstanding at a time, and returns read data / write ack to the miss handler.
module dcache_bypass_axi_if
  import dcache_bypass_axi_if_pkg::*;
#(
  parameter int                    AXI_ID_WIDTH = 4,
  parameter logic [AXI_ID_WIDTH-1:0] AXI_ID     = 4'b0001,
  parameter int                    ADDR_WIDTH   = 64,
  parameter int                    DATA_WIDTH   = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [1:0]              size_i,
  output logic                    gnt_o,
  output logic                    valid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o,
  output logic                    busy_o,
  dcache_bypass_axi_if_if.master  axi
);

  axi_bypass_state_e state_reg;
  bypass_req_t       req_reg;
  bypass_rsp_t       rsp_reg;
  logic              valid_reg;
  logic              aw_valid_reg;
  logic              w_valid_reg;
  logic              ar_valid_reg;
  logic              b_ready_reg;
  logic              r_ready_reg;

  logic aw_hs, w_hs, aw_done, w_done, b_hs, r_hs;

  // A dropped valid doubles as the "channel done" flag for the write phase.
  assign aw_hs   = aw_valid_reg & axi.aw_ready_i;
  assign w_hs    = w_valid_reg & axi.w_ready_i;
  assign aw_done = ~aw_valid_reg;
  assign w_done  = ~w_valid_reg;
  assign b_hs    = b_ready_reg & axi.b_valid_i;
  assign r_hs    = r_ready_reg & axi.r_valid_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg    <= IDLE;
      req_reg      <= '0;
      rsp_reg      <= '0;
      valid_reg    <= 1'b0;
      aw_valid_reg <= 1'b0;
      w_valid_reg  <= 1'b0;
      ar_valid_reg <= 1'b0;
      b_ready_reg  <= 1'b0;
      r_ready_reg  <= 1'b0;
    end else begin
      valid_reg   <= 1'b0;
      rsp_reg.err <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_i) begin
            req_reg <= '{we: we_i, addr: addr_i, wdata: wdata_i, be: be_i, size: size_i};
            if (we_i) begin
              state_reg    <= WR_ADDR_DATA;
              aw_valid_reg <= 1'b1;
              w_valid_reg  <= 1'b1;
            end else begin
              state_reg    <= RD_ADDR;
              ar_valid_reg <= 1'b1;
            end
          end
        end
        WR_ADDR_DATA: begin
          if (aw_hs) aw_valid_reg <= 1'b0;
          if (w_hs)  w_valid_reg  <= 1'b0;
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            state_reg   <= WR_RESP;
            b_ready_reg <= 1'b1;
          end
        end
        WR_RESP: begin
          if (b_hs) begin
            state_reg   <= IDLE;
            b_ready_reg <= 1'b0;
            valid_reg   <= 1'b1;
            rsp_reg.err <= axi_resp_is_err(axi.b_resp_i);
          end
        end
        RD_ADDR: begin
          if (ar_valid_reg && axi.ar_ready_i) begin
            state_reg    <= RD_DATA;
            ar_valid_reg <= 1'b0;
            r_ready_reg  <= 1'b1;
          end
        end
        RD_DATA: begin
          if (r_hs) begin
            state_reg     <= IDLE;
            r_ready_reg   <= 1'b0;
            valid_reg     <= 1'b1;
            rsp_reg.rdata <= axi.r_data_i;
            rsp_reg.err   <= axi_resp_is_err(axi.r_resp_i);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Grant is combinational so a held request is taken the cycle the FSM is back in IDLE.
  assign gnt_o   = req_i & rst_ni & (state_reg == IDLE);
  assign busy_o  = (state_reg != IDLE);
  assign valid_o = valid_reg;
  assign rdata_o = rsp_reg.rdata;
  assign err_o   = rsp_reg.err;

  assign axi.aw_valid_o = aw_valid_reg;
  assign axi.aw_addr_o  = req_reg.addr;
  assign axi.aw_size_o  = {1'b0, req_reg.size};
  assign axi.aw_len_o   = 8'd0;
  assign axi.aw_burst_o = AXI_BURST_INCR;
  assign axi.aw_id_o    = AXI_ID;

  assign axi.w_valid_o  = w_valid_reg;
  assign axi.w_data_o   = req_reg.wdata;
  assign axi.w_strb_o   = req_reg.be;
  assign axi.w_last_o   = 1'b1;

  assign axi.b_ready_o  = b_ready_reg;

  assign axi.ar_valid_o = ar_valid_reg;
  assign axi.ar_addr_o  = req_reg.addr;
  assign axi.ar_size_o  = {1'b0, req_reg.size};
  assign axi.ar_len_o   = 8'd0;
  assign axi.ar_burst_o = AXI_BURST_INCR;
  assign axi.ar_id_o    = AXI_ID;

  assign axi.r_ready_o  = r_ready_reg;

  // The direction is already encoded in the state and single beats make r_last redundant.
  logic unused_bits;
  assign unused_bits = req_reg.we ^ axi.r_last_i;

endmodule

// File: tb/tb_dcache_bypass_axi_if.sv
// Directed bench for dcache_bypass_axi_if: a configurable-delay AXI slave plus
// hand-timed transactions with expected values worked out per vector.
module tb_dcache_bypass_axi_if;

  logic        clk;
  logic        rst_ni;
  logic        req_i, we_i;
  logic [63:0] addr_i, wdata_i;
  logic [7:0]  be_i;
  logic [1:0]  size_i;
  logic        gnt_o, valid_o, err_o, busy_o;
  logic [63:0] rdata_o;

  dcache_bypass_axi_if_if #(.AXI_ID_WIDTH(4), .ADDR_WIDTH(64), .DATA_WIDTH(64)) bus ();

  dcache_bypass_axi_if #(
    .AXI_ID_WIDTH(4), .AXI_ID(4'b0001), .ADDR_WIDTH(64), .DATA_WIDTH(64)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .be_i(be_i), .size_i(size_i), .gnt_o(gnt_o),
    .valid_o(valid_o), .rdata_o(rdata_o), .err_o(err_o), .busy_o(busy_o),
    .axi(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_gnt = 0;
  int n_vld = 0;
  int n_txn = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave configuration, set by the main thread before each transaction.
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  logic [63:0] r_data_cfg = '0;

  int   aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic aw_hs_q, w_hs_q, ar_hs_q, b_hs_q, r_hs_q;
  logic aw_seen, w_seen, b_pend, r_pend;
  logic aw_stall_q, w_stall_q, ar_stall_q;
  logic [63:0] cap_aw_addr, cap_w_data, cap_ar_addr;
  logic [7:0]  cap_w_strb;
  logic [2:0]  cap_aw_size, cap_ar_size;

  initial begin
    bus.aw_ready_i = 1'b0; bus.w_ready_i = 1'b0; bus.ar_ready_i = 1'b0;
    bus.b_valid_i  = 1'b0; bus.b_resp_i  = 2'b00;
    bus.r_valid_i  = 1'b0; bus.r_data_i  = '0; bus.r_resp_i = 2'b00; bus.r_last_i = 1'b1;
  end

  // AXI slave: handshakes decided on one negedge take effect at the next one.
  always @(negedge clk) begin
    if (!rst_ni) begin
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
      aw_hs_q = 0; w_hs_q = 0; ar_hs_q = 0; b_hs_q = 0; r_hs_q = 0;
      aw_seen = 0; w_seen = 0; b_pend = 0; r_pend = 0;
      aw_stall_q = 0; w_stall_q = 0; ar_stall_q = 0;
      bus.aw_ready_i = 1'b0; bus.w_ready_i = 1'b0; bus.ar_ready_i = 1'b0;
      bus.b_valid_i = 1'b0; bus.r_valid_i = 1'b0;
    end else begin
      if (aw_stall_q) check_eq("aw_valid_held", bus.aw_valid_o, 1'b1);
      if (w_stall_q)  check_eq("w_valid_held", bus.w_valid_o, 1'b1);
      if (ar_stall_q) check_eq("ar_valid_held", bus.ar_valid_o, 1'b1);
      check_eq("one_txn_on_bus", (bus.aw_valid_o | bus.w_valid_o) & bus.ar_valid_o, 1'b0);
      if (aw_hs_q) aw_seen = 1;
      if (w_hs_q)  w_seen = 1;
      if (aw_seen && w_seen) begin b_pend = 1; b_cnt = 0; aw_seen = 0; w_seen = 0; end
      if (ar_hs_q) begin r_pend = 1; r_cnt = 0; end
      if (b_hs_q) b_pend = 0;
      if (r_hs_q) r_pend = 0;

      if (bus.aw_valid_o) begin bus.aw_ready_i = (aw_cnt >= aw_dly); aw_cnt++; end
      else begin bus.aw_ready_i = 1'b0; aw_cnt = 0; end
      if (bus.w_valid_o) begin bus.w_ready_i = (w_cnt >= w_dly); w_cnt++; end
      else begin bus.w_ready_i = 1'b0; w_cnt = 0; end
      if (bus.ar_valid_o) begin bus.ar_ready_i = (ar_cnt >= ar_dly); ar_cnt++; end
      else begin bus.ar_ready_i = 1'b0; ar_cnt = 0; end
      bus.b_valid_i = b_pend && (b_cnt >= b_dly);
      if (b_pend) b_cnt++;
      bus.r_valid_i = r_pend && (r_cnt >= r_dly);
      if (r_pend) r_cnt++;
      bus.b_resp_i = b_resp_cfg;
      bus.r_resp_i = r_resp_cfg;
      bus.r_data_i = r_data_cfg;

      aw_hs_q = bus.aw_valid_o & bus.aw_ready_i;
      w_hs_q  = bus.w_valid_o & bus.w_ready_i;
      ar_hs_q = bus.ar_valid_o & bus.ar_ready_i;
      b_hs_q  = bus.b_valid_i & bus.b_ready_o;
      r_hs_q  = bus.r_valid_i & bus.r_ready_o;
      aw_stall_q = bus.aw_valid_o & ~bus.aw_ready_i;
      w_stall_q  = bus.w_valid_o & ~bus.w_ready_i;
      ar_stall_q = bus.ar_valid_o & ~bus.ar_ready_i;
      if (aw_hs_q) begin cap_aw_addr = bus.aw_addr_o; cap_aw_size = bus.aw_size_o; end
      if (w_hs_q)  begin cap_w_data = bus.w_data_o; cap_w_strb = bus.w_strb_o; end
      if (ar_hs_q) begin cap_ar_addr = bus.ar_addr_o; cap_ar_size = bus.ar_size_o; end
    end
  end

  always @(negedge clk) begin
    #2;
    if (gnt_o)   n_gnt++;
    if (valid_o) n_vld++;
  end

  logic [63:0] hold_rdata = '0;

  // Issue one request, wait for its response and check it against the slave setup.
  task automatic do_txn(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [7:0] be, input logic [1:0] size, input logic [1:0] resp,
                        input logic [63:0] rdat, input int exp_lat);
    int lat;
    b_resp_cfg = resp; r_resp_cfg = resp; r_data_cfg = rdat;
    @(negedge clk);
    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata; be_i = be; size_i = size;
    #1;
    check_eq("txn_gnt", gnt_o, 1'b1);
    lat = 0;
    do begin
      @(negedge clk);
      req_i = 1'b0;
      #1;
      lat++;
    end while (!valid_o && lat < 200);
    check_eq("txn_timeout", valid_o, 1'b1);
    if (exp_lat >= 0) check_eq("txn_latency", lat, exp_lat);
    check_eq("txn_err", err_o, resp != 2'b00);
    if (we) begin
      check_eq("txn_rdata_held", rdata_o, hold_rdata);
      check_eq("txn_aw_addr", cap_aw_addr, addr);
      check_eq("txn_aw_size", cap_aw_size, {1'b0, size});
      check_eq("txn_w_data", cap_w_data, wdata);
      check_eq("txn_w_strb", cap_w_strb, be);
    end else begin
      hold_rdata = rdat;
      check_eq("txn_rdata", rdata_o, rdat);
      check_eq("txn_ar_addr", cap_ar_addr, addr);
      check_eq("txn_ar_size", cap_ar_size, {1'b0, size});
    end
    n_txn++;
    $display("txn %0d we=%0b addr=%h lat=%0d err=%0b rdata=%h", n_txn, we, addr, lat, err_o, rdata_o);
  endtask

  // Stall pattern table: aw, w, b, ar, r delays.
  int stall_tbl [8][5] = '{
    '{0, 0, 0, 0, 0}, '{2, 0, 1, 1, 0}, '{0, 4, 0, 0, 3}, '{3, 3, 2, 2, 2},
    '{1, 0, 5, 4, 1}, '{0, 1, 0, 0, 6}, '{5, 2, 3, 3, 0}, '{1, 1, 1, 1, 1}
  };

  initial begin
    rst_ni = 1'b0; req_i = 1'b1; we_i = 1'b0; addr_i = '0; wdata_i = '0; be_i = '0; size_i = '0;

    // Reset with a request pending: nothing may be granted or driven.
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_gnt", gnt_o, 1'b0);
    check_eq("rst_busy", busy_o, 1'b0);
    check_eq("rst_valid", valid_o, 1'b0);
    check_eq("rst_err", err_o, 1'b0);
    check_eq("rst_rdata", rdata_o, 64'h0);
    check_eq("rst_axi_valids", {bus.aw_valid_o, bus.w_valid_o, bus.ar_valid_o}, 3'b000);
    check_eq("rst_axi_readies", {bus.b_ready_o, bus.r_ready_o}, 2'b00);
    req_i = 1'b0;
    rst_ni = 1'b1;
    @(negedge clk);

    // Zero-wait read, cycle by cycle.
    r_data_cfg = 64'hDEADBEEF_CAFEBABE; r_resp_cfg = 2'b00;
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; addr_i = 64'h1000_0008; size_i = 2'd3; #1;
    check_eq("rd_c0_gnt", gnt_o, 1'b1);
    check_eq("rd_c0_busy", busy_o, 1'b0);
    @(negedge clk); req_i = 1'b0; #1;
    check_eq("rd_c1_ar_valid", bus.ar_valid_o, 1'b1);
    check_eq("rd_c1_ar_addr", bus.ar_addr_o, 64'h1000_0008);
    check_eq("rd_c1_ar_len", bus.ar_len_o, 8'd0);
    check_eq("rd_c1_ar_size", bus.ar_size_o, 3'd3);
    check_eq("rd_c1_ar_burst", bus.ar_burst_o, 2'b01);
    check_eq("rd_c1_ar_id", bus.ar_id_o, 4'b0001);
    check_eq("rd_c1_busy", busy_o, 1'b1);
    @(negedge clk); #1;
    check_eq("rd_c2_r_ready", bus.r_ready_o, 1'b1);
    check_eq("rd_c2_valid", valid_o, 1'b0);
    @(negedge clk); #1;
    check_eq("rd_c3_valid", valid_o, 1'b1);
    check_eq("rd_c3_rdata", rdata_o, 64'hDEADBEEF_CAFEBABE);
    check_eq("rd_c3_err", err_o, 1'b0);
    check_eq("rd_c3_busy", busy_o, 1'b0);
    @(negedge clk); #1;
    check_eq("rd_c4_valid_pulse", valid_o, 1'b0);
    check_eq("rd_c4_rdata_hold", rdata_o, 64'hDEADBEEF_CAFEBABE);
    hold_rdata = 64'hDEADBEEF_CAFEBABE;
    $display("txn dir read lat=3 rdata=%h", rdata_o);

    // Write with AW accepted immediately and W stalled three cycles.
    w_dly = 3; b_resp_cfg = 2'b00;
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; addr_i = 64'h2000_0010; wdata_i = 64'h11; be_i = 8'h01; size_i = 2'd0; #1;
    check_eq("wr_c0_gnt", gnt_o, 1'b1);
    @(negedge clk); req_i = 1'b0; #1;
    check_eq("wr_c1_aw_valid", bus.aw_valid_o, 1'b1);
    check_eq("wr_c1_w_valid", bus.w_valid_o, 1'b1);
    check_eq("wr_c1_aw_addr", bus.aw_addr_o, 64'h2000_0010);
    check_eq("wr_c1_aw_size", bus.aw_size_o, 3'd0);
    check_eq("wr_c1_w_data", bus.w_data_o, 64'h11);
    check_eq("wr_c1_w_strb", bus.w_strb_o, 8'h01);
    check_eq("wr_c1_w_last", bus.w_last_o, 1'b1);
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk); #1;
      check_eq("wr_aw_dropped", bus.aw_valid_o, 1'b0);
      check_eq("wr_w_still_valid", bus.w_valid_o, 1'b1);
      check_eq("wr_no_early_valid", valid_o, 1'b0);
    end
    @(negedge clk); #1;
    check_eq("wr_c5_w_valid", bus.w_valid_o, 1'b0);
    check_eq("wr_c5_b_ready", bus.b_ready_o, 1'b1);
    @(negedge clk); #1;
    check_eq("wr_c6_valid", valid_o, 1'b1);
    check_eq("wr_c6_err", err_o, 1'b0);
    check_eq("wr_c6_rdata_hold", rdata_o, 64'hDEADBEEF_CAFEBABE);
    @(negedge clk); #1;
    check_eq("wr_c7_valid_pulse", valid_o, 1'b0);
    w_dly = 0;
    $display("txn dir write lat=6");

    // Error responses.
    do_txn(1'b1, 64'h3000_0000, 64'hA5A5_A5A5_0000_FFFF, 8'hFF, 2'd3, 2'b10, 64'h0, 3);
    do_txn(1'b0, 64'h3000_0040, 64'h0, 8'h00, 2'd2, 2'b11, 64'h0BAD_F00D_1234_5678, 3);

    // Back-to-back read then write with req held high.
    r_data_cfg = 64'h0123_4567_89AB_CDEF; r_resp_cfg = 2'b00; b_resp_cfg = 2'b00;
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; addr_i = 64'h4000_0000; size_i = 2'd3; #1;
    check_eq("b2b_c0_gnt", gnt_o, 1'b1);
    @(negedge clk);
    we_i = 1'b1; addr_i = 64'h4000_0100; wdata_i = 64'hFEED; be_i = 8'h03; size_i = 2'd1; #1;
    check_eq("b2b_c1_gnt", gnt_o, 1'b0);
    @(negedge clk); #1;
    check_eq("b2b_c2_gnt", gnt_o, 1'b0);
    @(negedge clk); #1;
    check_eq("b2b_c3_valid", valid_o, 1'b1);
    check_eq("b2b_c3_gnt", gnt_o, 1'b1);
    check_eq("b2b_c3_rdata", rdata_o, 64'h0123_4567_89AB_CDEF);
    @(negedge clk); req_i = 1'b0; #1;
    check_eq("b2b_c4_aw_w", {bus.aw_valid_o, bus.w_valid_o}, 2'b11);
    check_eq("b2b_c4_valid", valid_o, 1'b0);
    @(negedge clk); #1;
    check_eq("b2b_c5_b_ready", bus.b_ready_o, 1'b1);
    @(negedge clk); #1;
    check_eq("b2b_c6_valid", valid_o, 1'b1);
    check_eq("b2b_c6_w_data", cap_w_data, 64'hFEED);
    check_eq("b2b_c6_rdata_hold", rdata_o, 64'h0123_4567_89AB_CDEF);
    $display("txn dir back-to-back read+write");

    // Reset while waiting in RD_DATA: the read is abandoned and rdata cleared.
    r_dly = 5;
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; addr_i = 64'h5000_0008; size_i = 2'd3; #1;
    check_eq("rrst_c0_gnt", gnt_o, 1'b1);
    @(negedge clk); req_i = 1'b0;
    @(negedge clk); #1;
    check_eq("rrst_c2_r_ready", bus.r_ready_o, 1'b1);
    check_eq("rrst_c2_r_valid", bus.r_valid_i, 1'b0);
    rst_ni = 1'b0;
    @(negedge clk); #1;
    check_eq("rrst_c3_busy", busy_o, 1'b0);
    check_eq("rrst_c3_valids", {bus.aw_valid_o, bus.w_valid_o, bus.ar_valid_o, valid_o}, 4'b0000);
    check_eq("rrst_c3_readies", {bus.b_ready_o, bus.r_ready_o}, 2'b00);
    check_eq("rrst_c3_rdata", rdata_o, 64'h0);
    rst_ni = 1'b1;
    r_dly = 0;
    hold_rdata = 64'h0;
    $display("txn dir reset in RD_DATA");
    do_txn(1'b0, 64'h5000_0010, 64'h0, 8'h00, 2'd3, 2'b00, 64'h5555_AAAA_5555_AAAA, 3);

    // Stalled channels, write then read per table entry.
    for (int i = 0; i < 8; i++) begin
      int mx;
      aw_dly = stall_tbl[i][0]; w_dly = stall_tbl[i][1]; b_dly = stall_tbl[i][2];
      ar_dly = stall_tbl[i][3]; r_dly = stall_tbl[i][4];
      mx = (aw_dly > w_dly) ? aw_dly : w_dly;
      do_txn(1'b1, 64'h6000_0000 + 64'(i * 8), 64'hC0DE_0000 + 64'(i), 8'h0F << (i % 5),
             2'(i % 4), 2'(i % 3 == 2 ? 2 : 0), 64'h0, 3 + mx + b_dly);
      do_txn(1'b0, 64'h7000_0000 + 64'(i * 16), 64'h0, 8'h00, 2'd3,
             2'(i % 4 == 3 ? 3 : 0), 64'h1111_0000_0000_0000 + 64'(i), 3 + ar_dly + r_dly);
    end

    repeat (3) @(negedge clk);
    #3;
    // One grant was taken by the read that reset abandoned.
    check_eq("gnt_vs_valid", n_gnt, n_vld + 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
